// File: rtl/tictactoe_pkg.sv
// Shared types and the winning-line table for the tic-tac-toe result scanner.
package tictactoe_pkg;

  // Two-bit cell encoding as stored in the pos1..pos9 registers.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PL_O  = 2'b01,
    PL_X  = 2'b10,
    BAD   = 2'b11
  } cell_t;

  // Scanner control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } scan_state_t;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;

  // Winning lines as zero-based cell indices (cell 0 is pos1, row-major).
  // Rows, then columns, then the two diagonals.
  localparam logic [3:0] LINE_TBL [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/board_win_scanner_line_match.sv
// Combinational check of one three-cell line: all equal and owned by a player.
module line_match
  import tictactoe_pkg::*;
(
  input  cell_t a,
  input  cell_t b,
  input  cell_t c,
  output logic  match,
  output cell_t owner
);

  // Empty and invalid cells never form a line, even when all three agree.
  always_comb begin
    match = (a == b) && (b == c) && ((a == PL_O) || (a == PL_X));
    owner = match ? a : EMPTY;
  end

endmodule

// File: rtl/board_win_scanner.sv
// Snapshots the board on start, then walks the eight winning lines one per
// clock and reports win / draw / corrupt-board results with registered outputs.
module board_win_scanner
  import tictactoe_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       busy,
  output logic       done,
  output logic       winner_x,
  output logic       winner_o,
  output logic       draw,
  output logic       board_err,
  output logic [2:0] win_line,
  output logic [3:0] occupied_cnt
);

  cell_t       pos_in [NUM_CELLS];
  cell_t       snap_q [NUM_CELLS];
  cell_t       snap_d [NUM_CELLS];
  scan_state_t state_q, state_d;
  logic [2:0]  line_idx_q, line_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        winner_x_q, winner_x_d;
  logic        winner_o_q, winner_o_d;
  logic        draw_q, draw_d;
  logic        board_err_q, board_err_d;
  logic [2:0]  win_line_q, win_line_d;
  logic [3:0]  occupied_cnt_q, occupied_cnt_d;

  logic [3:0]  pop_cnt;
  logic        any_bad;
  cell_t       sel_cell [3];
  logic        line_hit;
  cell_t       line_owner;
  logic        win_seen;

  assign pos_in[0] = cell_t'(pos1);
  assign pos_in[1] = cell_t'(pos2);
  assign pos_in[2] = cell_t'(pos3);
  assign pos_in[3] = cell_t'(pos4);
  assign pos_in[4] = cell_t'(pos5);
  assign pos_in[5] = cell_t'(pos6);
  assign pos_in[6] = cell_t'(pos7);
  assign pos_in[7] = cell_t'(pos8);
  assign pos_in[8] = cell_t'(pos9);

  // Occupied-cell popcount and invalid-cell detect over the board being latched.
  always_comb begin
    pop_cnt = 4'd0;
    any_bad = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if ((pos_in[i] == PL_O) || (pos_in[i] == PL_X)) pop_cnt = pop_cnt + 4'd1;
      if (pos_in[i] == BAD) any_bad = 1'b1;
    end
  end

  // Route the three snapshot cells of the current line to the single matcher.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      sel_cell[j] = snap_q[LINE_TBL[line_idx_q][j]];
    end
  end

  line_match u_line_match (
    .a     (sel_cell[0]),
    .b     (sel_cell[1]),
    .c     (sel_cell[2]),
    .match (line_hit),
    .owner (line_owner)
  );

  // Next-state and next-result logic for the IDLE/SCAN/DONE controller.
  always_comb begin
    state_d        = state_q;
    line_idx_d     = line_idx_q;
    snap_d         = snap_q;
    done_d         = 1'b0;
    winner_x_d     = winner_x_q;
    winner_o_d     = winner_o_q;
    draw_d         = draw_q;
    board_err_d    = board_err_q;
    win_line_d     = win_line_q;
    occupied_cnt_d = occupied_cnt_q;
    win_seen       = winner_x_q | winner_o_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d         = pos_in;
          line_idx_d     = 3'd0;
          winner_x_d     = 1'b0;
          winner_o_d     = 1'b0;
          draw_d         = 1'b0;
          win_line_d     = 3'd0;
          occupied_cnt_d = pop_cnt;
          board_err_d    = any_bad;
          state_d        = SCAN;
        end
      end

      SCAN: begin
        if (line_hit && !win_seen) begin
          winner_x_d = (line_owner == PL_X);
          winner_o_d = (line_owner == PL_O);
          win_line_d = line_idx_q;
        end else if (line_hit && ((line_owner == PL_X) != winner_x_q)) begin
          // Both players own a line: keep the first win, flag the board.
          board_err_d = 1'b1;
        end

        if (EARLY_EXIT && line_hit && !win_seen) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (line_idx_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
          draw_d  = (occupied_cnt_q == 4'd9) && !(winner_x_d | winner_o_d) && !board_err_d;
        end else begin
          line_idx_d = line_idx_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, snapshot and result registers; reset wins over any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      line_idx_q     <= 3'd0;
      snap_q         <= '{default: EMPTY};
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winner_x_q     <= 1'b0;
      winner_o_q     <= 1'b0;
      draw_q         <= 1'b0;
      board_err_q    <= 1'b0;
      win_line_q     <= 3'd0;
      occupied_cnt_q <= 4'd0;
    end else begin
      state_q        <= state_d;
      line_idx_q     <= line_idx_d;
      snap_q         <= snap_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      winner_x_q     <= winner_x_d;
      winner_o_q     <= winner_o_d;
      draw_q         <= draw_d;
      board_err_q    <= board_err_d;
      win_line_q     <= win_line_d;
      occupied_cnt_q <= occupied_cnt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign winner_x     = winner_x_q;
  assign winner_o     = winner_o_q;
  assign draw         = draw_q;
  assign board_err    = board_err_q;
  assign win_line     = win_line_q;
  assign occupied_cnt = occupied_cnt_q;

endmodule
